day2_stream_arb_mux: RTL and testbench
======================================

Name: day2_stream_arb_mux

Overview:
Parametrised N-channel, WIDTH-bit valid/ready stream multiplexer. It is the successor to the 2:1 combinational data select. It arbitrates between N_CH input streams, either round-robin or fixed priority, and holds the grant for a whole packet (until `last`). The selected beat goes through a single registered output stage that carries the source channel index. It sits between multiple producer blocks and one shared downstream consumer.

Parameters:
N_CH, 4, number of input channels; must be at least 2.
WIDTH, 8, data width per channel in bits.
MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
CH_W, $clog2(N_CH), width of the channel index; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
in_data  input  N_CH*WIDTH  channel i data on in_data[i*WIDTH +: WIDTH].
in_valid  input  N_CH  per-channel beat valid.
in_last  input  N_CH  per-channel end-of-packet marker, qualified by in_valid.
in_ready  output  N_CH  per-channel accept; at most one bit high per cycle.
out_data  output  WIDTH  registered selected data.
out_valid  output  1  output beat valid.
out_last  output  1  registered last of the output beat.
out_ch  output  CH_W  source channel of the output beat.
out_ready  input  1  downstream accept.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - Lock flag cleared.
  - RR pointer last_grant=N_CH-1, so ch0 has first priority.
  - in_ready=0 while rst_n=0.
- Load enable: load_en = !out_valid || out_ready.
  - in_ready is combinational from in_valid, the lock state, the pointer and out_ready.
  - No other combinational input-to-output paths exist.
- Grant when unlocked and load_en=1:
  - MODE 0: first valid channel searching from last_grant+1 upward, wrapping modulo N_CH.
  - MODE 1: lowest-index valid channel.
  - The granted channel gets in_ready=1; all others get 0.
- Accepted beat: an accepted beat is in_valid[g] && in_ready[g]. On an accepted beat the output register loads data, last and out_ch=g, and out_valid is set to 1.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Output drain: if load_en=1 and no beat is accepted, out_valid becomes 0 at the next edge. out_data, out_last and out_ch then hold their last values.
- Throughput: 1 beat/cycle while out_ready=1.
- Packet lock:
  - Accepting a beat with in_last=0 sets lock=1 with locked channel g.
  - While locked, only g can be granted, even if in_valid[g]=0. Other channels stall and in_ready stays 0.
  - Accepting a beat from g with in_last=1 clears the lock.
- Pointer:
  - last_grant updates to g only when a beat with in_last=1 is accepted, so arbitration is per packet.
  - Single-beat packets are beats with last=1.
  - The pointer is unused in MODE 1 but is still maintained.
- Backpressure: while out_valid=1 and out_ready=0, all output registers hold and every in_ready bit is 0.
- Simultaneous events: out_ready=1 together with a new accepted beat in the same cycle replaces the output beat. There is no bubble and no loss.
- Reset mid-operation: rst_n=0 at any edge forces the reset values above.
  - Any in-flight output beat and any partial packet are discarded.
  - The lock is cleared; no recovery of the partial packet is attempted.
- Wrap-around: from last_grant=N_CH-1 the search begins at ch0.
- Grant safety: grants to a channel with in_valid=0 never occur. An unlocked cycle with no valid input accepts nothing.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 3 cycles with all in_valid=1 and out_ready=1.
   - Response: out_valid=0 and in_ready=4'b0000 throughout reset.
   - Response: after release, the first output beat has out_ch=0 and appears 1 cycle after acceptance.
2. Round-robin fairness:
   - Stimulus: MODE=0, N_CH=4, all channels valid with single-beat packets (last=1), data ch_i=8'h10+i, out_ready=1.
   - Response: out_ch sequence is 0,1,2,3,0,1,... with out_data 8'h10,8'h11,8'h12,8'h13.
   - Response: one beat per cycle.
3. Packet lock:
   - Stimulus: ch1 sends a 3-beat packet (8'hA1,8'hA2,8'hA3; last on the third beat) with in_valid[1]=0 for 2 cycles between beats 2 and 3; ch2 is valid throughout.
   - Response: ch2 is never granted until 8'hA3 is accepted.
   - Response: ch2's beat appears on out_data the cycle after 8'hA3 appears.
4. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles while out_valid=1 with out_data=8'h5C.
   - Response: out_data, out_ch and out_last stay stable; in_ready=0.
   - Stimulus: raise out_ready.
   - Response: 8'h5C completes and the next beat follows on the following cycle with no loss or duplication.
5. Fixed priority:
   - Stimulus: MODE=1 with ch0 and ch3 continuously valid (single-beat).
   - Response: only out_ch=0 is observed.
   - Stimulus: drop in_valid[0].
   - Response: ch3 is granted in the same cycle and its beat is on the output the next cycle.
6. Reset mid-packet:
   - Stimulus: during beat 2 of a 4-beat ch2 packet, pulse rst_n=0 for 1 cycle.
   - Response: out_valid=0 at the next edge and the lock is cleared.
   - Stimulus: after release, with ch0 and ch2 both valid.
   - Response: ch0 is granted first.

Source files
------------

// File: rtl/day2_stream_arb_mux.sv
// rtl/day2_stream_arb_mux.sv - N-channel valid/ready stream arbiter-mux with packet lock and registered output
//
// Purpose: arbitrates N_CH input streams (round-robin or fixed priority),
// holds the grant for a whole packet (until in_last), and drives one shared
// consumer through a single registered output stage tagged with the source
// channel index.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    channel i data on in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel end-of-packet, qualified by in_valid
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected data
//   out_valid  output beat valid
//   out_last   registered last of the output beat
//   out_ch     source channel of the output beat
//   out_ready  downstream accept
module day2_stream_arb_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH-1:0]         in_last,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             lock_q, lock_d;
  logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;

  logic             load_en;
  logic             gnt_vld;
  logic [CH_W-1:0]  gnt_ch;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;

  assign load_en = !out_valid_q || out_ready;

  // Grant selection. Loops run from the far end downward so the candidate
  // closest to the search start is written last and therefore wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    if (rst_n && load_en) begin
      if (lock_q) begin
        // A locked packet owns the output even while its source idles.
        gnt_vld = in_valid[lock_ch_q];
        gnt_ch  = lock_ch_q;
      end else if (MODE == 1) begin
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (in_valid[CH_W'(i)]) begin
            gnt_vld = 1'b1;
            gnt_ch  = CH_W'(i);
          end
        end
      end else begin
        for (int k = N_CH; k >= 1; k--) begin
          idx = int'(last_grant_q) + k;
          if (idx >= N_CH) idx = idx - N_CH;
          if (in_valid[CH_W'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_ch  = CH_W'(idx);
          end
        end
      end
    end
  end

  assign in_ready = gnt_vld ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_ch) : '0;
  assign acc_last = in_last[gnt_ch];
  assign acc_data = in_data[gnt_ch*WIDTH +: WIDTH];

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_ch_d     = out_ch_q;
    lock_d       = lock_q;
    lock_ch_d    = lock_ch_q;
    last_grant_d = last_grant_q;
    if (gnt_vld) begin
      out_data_d  = acc_data;
      out_valid_d = 1'b1;
      out_last_d  = acc_last;
      out_ch_d    = gnt_ch;
      if (acc_last) begin
        // Pointer advances per packet, not per beat.
        lock_d       = 1'b0;
        last_grant_d = gnt_ch;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = gnt_ch;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_ch_q     <= '0;
      lock_q       <= 1'b0;
      lock_ch_q    <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_ch_q     <= out_ch_d;
      lock_q       <= lock_d;
      lock_ch_q    <= lock_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_day2_stream_arb_mux.sv
// tb/tb_day2_stream_arb_mux.sv - bench for day2_stream_arb_mux, round-robin and fixed-priority instances
module tb_day2_stream_arb_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last;
  logic           out_ready;

  logic [N-1:0] rdy0, rdy1;
  logic [W-1:0] od0, od1;
  logic         ov0, ov1, ol0, ol1;
  logic [1:0]   oc0, oc1;

  day2_stream_arb_mux #(.N_CH(N), .WIDTH(W), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy0), .out_data(od0), .out_valid(ov0),
    .out_last(ol0), .out_ch(oc0), .out_ready(out_ready));

  day2_stream_arb_mux #(.N_CH(N), .WIDTH(W), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy1), .out_data(od1), .out_valid(ov1),
    .out_last(ol1), .out_ch(oc1), .out_ready(out_ready));

  int checks = 0;
  int failures = 0;

  // Reference model, index 0 = round-robin instance, 1 = fixed priority.
  int m_ptr[2], m_lch[2], m_oc[2], m_od[2];
  bit m_lock[2], m_ov[2], m_ol[2];

  function automatic logic [31:0] dut_rdy(int m);
    return (m == 0) ? 32'(rdy0) : 32'(rdy1);
  endfunction
  function automatic logic [31:0] dut_od(int m);
    return (m == 0) ? 32'(od0) : 32'(od1);
  endfunction
  function automatic logic [31:0] dut_ov(int m);
    return (m == 0) ? 32'(ov0) : 32'(ov1);
  endfunction
  function automatic logic [31:0] dut_ol(int m);
    return (m == 0) ? 32'(ol0) : 32'(ol1);
  endfunction
  function automatic logic [31:0] dut_oc(int m);
    return (m == 0) ? 32'(oc0) : 32'(oc1);
  endfunction

  task automatic chk(input string tag, input int m, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s inst%0d got=%h exp=%h", tag, m, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = N - 1; m_lock[m] = 0; m_lch[m] = 0;
      m_ov[m] = 0; m_od[m] = 0; m_ol[m] = 0; m_oc[m] = 0;
    end
  endfunction

  // Which channel the arbitration rules pick this cycle, -1 for none.
  function automatic int model_grant(int m);
    int c;
    if (!rst_n) return -1;
    if (m_ov[m] && !out_ready) return -1;
    if (m_lock[m]) return in_valid[m_lch[m]] ? m_lch[m] : -1;
    for (int k = 1; k <= N; k++) begin
      c = (m == 1) ? k - 1 : (m_ptr[m] + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    int g[2];
    logic [31:0] exp_r;
    #1;
    for (int m = 0; m < 2; m++) begin
      g[m] = model_grant(m);
      exp_r = (g[m] >= 0) ? (32'd1 << g[m]) : 32'd0;
      chk("in_ready", m, dut_rdy(m), exp_r);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_ptr[m] = N - 1; m_lock[m] = 0; m_lch[m] = 0;
        m_ov[m] = 0; m_od[m] = 0; m_ol[m] = 0; m_oc[m] = 0;
      end else if (g[m] >= 0) begin
        m_ov[m] = 1;
        m_od[m] = int'(in_data[g[m]*W +: W]);
        m_ol[m] = in_last[g[m]];
        m_oc[m] = g[m];
        if (in_last[g[m]]) begin
          m_lock[m] = 0; m_ptr[m] = g[m];
        end else begin
          m_lock[m] = 1; m_lch[m] = g[m];
        end
      end else if (!m_ov[m] || out_ready) begin
        m_ov[m] = 0;
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("out_valid", m, dut_ov(m), 32'(m_ov[m]));
      chk("out_data", m, dut_od(m), 32'(m_od[m]));
      chk("out_last", m, dut_ol(m), 32'(m_ol[m]));
      chk("out_ch", m, dut_oc(m), 32'(m_oc[m]));
    end
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 4'hF; in_last = 4'hF;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);

    // Reset with everything valid: no grants, outputs cleared.
    repeat (3) step();
    chk("reset_ov", 0, 32'(ov0), 32'd0);
    chk("reset_rdy", 0, 32'(rdy0), 32'd0);

    // Round-robin fairness with single-beat packets.
    rst_n = 1'b1;
    step();
    chk("first_ch", 0, 32'(oc0), 32'd0);
    chk("first_data", 0, 32'(od0), 32'h10);
    step();
    chk("rr_second", 0, 32'(oc0), 32'd1);
    repeat (7) step();

    // Packet lock: ch1 three beats with a gap, ch2 waiting.
    in_valid = 4'b0010; in_last = 4'b0000; set_data(8'h00, 8'hA1, 8'h22, 8'h00);
    step();
    in_valid = 4'b0110; in_last = 4'b0100; set_data(8'h00, 8'hA2, 8'h22, 8'h00);
    step();
    in_valid = 4'b0100;
    repeat (2) step();
    chk("lock_stall", 0, 32'(rdy0), 32'd0);
    in_valid = 4'b0110; in_last = 4'b0110; set_data(8'h00, 8'hA3, 8'h22, 8'h00);
    step();
    chk("lock_a3", 0, 32'(od0), 32'hA3);
    in_valid = 4'b0100;
    step();
    chk("lock_ch2", 0, 32'(oc0), 32'd2);
    in_valid = 4'b0000;
    step();

    // Backpressure holding 8'h5C.
    in_valid = 4'b0001; in_last = 4'b1111; set_data(8'h5C, 8'h00, 8'h00, 8'h00);
    step();
    set_data(8'h5D, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", 0, 32'(od0), 32'h5C);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", 0, 32'(od0), 32'h5D);
    in_valid = 4'b0000;
    step();

    // Fixed priority: ch0 and ch3 valid, then ch0 drops.
    in_valid = 4'b1001; in_last = 4'b1111; set_data(8'h30, 8'h00, 8'h00, 8'h33);
    repeat (4) step();
    chk("fp_ch0", 1, 32'(oc1), 32'd0);
    in_valid = 4'b1000;
    step();
    chk("fp_ch3", 1, 32'(oc1), 32'd3);
    step();

    // Reset in the middle of a ch2 packet.
    in_valid = 4'b0100; in_last = 4'b0000; set_data(8'h40, 8'h00, 8'h42, 8'h00);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_ov", 0, 32'(ov0), 32'd0);
    rst_n = 1'b1; in_valid = 4'b0101; in_last = 4'b0101;
    step();
    chk("post_rst_ch", 0, 32'(oc0), 32'd0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = 32'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
